// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     raw_rs_q, raw_rs_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic                 done_q, done_d;

  logic                 sel_mult, sel_multu, sel_div, sel_divu, sel_mthi, sel_mtlo;
  logic                 sel_signed, sel_iter;
  logic [WIDTH-1:0]     rs_abs, rt_abs;
  logic [WIDTH:0]       mul_sum, div_shift, div_trial;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Strobes should be one-hot; the cascade below resolves any overlap by priority.
  always_comb begin
    sel_mult  = op_mult;
    sel_multu = !op_mult && op_multu;
    sel_div   = !op_mult && !op_multu && op_div;
    sel_divu  = !op_mult && !op_multu && !op_div && op_divu;
    sel_mthi  = !op_mult && !op_multu && !op_div && !op_divu && op_mthi;
    sel_mtlo  = !op_mult && !op_multu && !op_div && !op_divu && !op_mthi && op_mtlo;
  end

  assign sel_signed = sel_mult || sel_div;
  assign sel_iter   = sel_mult || sel_multu || sel_div || sel_divu;
  assign rs_abs     = (sel_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_abs     = (sel_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Multiply: the multiplier sits in acc low half and is consumed LSB first.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  // Divide: the dividend sits in acc low half; quotient bits shift in from the right.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};
  assign div_ok    = !div_trial[WIDTH];

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    raw_rs_d   = raw_rs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_iter) begin
            state_d    = RUN;
            cnt_d      = CW'(WIDTH - 1);
            acc_d      = {{WIDTH{1'b0}}, rs_abs};
            rem_d      = '0;
            dvs_d      = rt_abs;
            raw_rs_d   = rs_data;
            is_div_d   = sel_div || sel_divu;
            neg_res_d  = sel_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem_d  = sel_div && rs_data[WIDTH-1];
            div_zero_d = (rt_data == '0);
            // Multiply keeps multiplicand in dvs and multiplier in acc low half.
            if (!(sel_div || sel_divu)) begin
              acc_d = {{WIDTH{1'b0}}, rt_abs};
              dvs_d = rs_abs;
            end
          end else if (sel_mthi) begin
            hi_d = rs_data;
          end else if (sel_mtlo) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
          rem_d = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div_zero_q) begin
          hi_d = raw_rs_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      raw_rs_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      raw_rs_q   <= raw_rs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
